// File: rtl/loop_nco.sv
// loop_nco: numerically controlled oscillator for the CDR loop.
// Converts the loop-filter control word speed_var into a phase step,
// accumulates phase, and emits edge (wrap) and centre (half-phase) strobes.
// Optional lock detector is built when LOOP_NCO_LOCK_DET_EN is defined;
// otherwise locked is tied low.
module loop_nco #(
   parameter int ACC_W      = 16,
   parameter int BASE_INC   = 4096,
   parameter int GAIN_SHIFT = 2,
   parameter int LOCK_WIN   = 4,
   parameter int LOCK_CNT   = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       speed_var,
   output logic             edge_stb,
   output logic             center_stb,
   output logic [ACC_W-1:0] phase,
   output logic [ACC_W-1:0] inc,
   output logic             locked
);

   // Step arithmetic is done signed with two guard bits so the offset
   // term can go negative before clamping.
   localparam int RW = ACC_W + 2;
   localparam logic signed [RW-1:0] INC_MAX  = RW'(2**(ACC_W-1));
   localparam logic signed [RW-1:0] INC_MIN  = RW'(1);
   localparam logic signed [RW-1:0] INC_BASE = RW'(BASE_INC);
   localparam logic signed [RW-1:0] OFF_MID  = RW'(128);

   logic signed [RW-1:0] off;
   logic signed [RW-1:0] raw;
   logic [ACC_W-1:0]     inc_nxt;
   logic [ACC_W:0]       sum;

   // Step from control word, clamped so a period is never shorter than 2 cycles.
   always_comb begin
      off = $signed({{(RW-8){1'b0}}, speed_var}) - OFF_MID;
      raw = INC_BASE + (off <<< GAIN_SHIFT);
      if (raw < INC_MIN)
         inc_nxt = ACC_W'(1);
      else if (raw > INC_MAX)
         inc_nxt = INC_MAX[ACC_W-1:0];
      else
         inc_nxt = raw[ACC_W-1:0];
   end

   assign sum = {1'b0, phase} + {1'b0, inc};

   // Step register tracks speed_var every cycle, independent of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inc <= ACC_W'(BASE_INC);
      else
         inc <= inc_nxt;
   end

   // Phase accumulator with registered wrap and half-phase strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= '0;
         edge_stb   <= 1'b0;
         center_stb <= 1'b0;
      end else if (en) begin
         phase      <= sum[ACC_W-1:0];
         edge_stb   <= sum[ACC_W];
         center_stb <= ~phase[ACC_W-1] & sum[ACC_W-1];
      end else begin
         edge_stb   <= 1'b0;
         center_stb <= 1'b0;
      end
   end

`ifdef LOOP_NCO_LOCK_DET_EN
   localparam int CW = $clog2(LOCK_CNT + 1);

   logic [7:0]        ref_sv;
   logic              first_edge;
   logic [CW-1:0]     lock_cnt;
   logic signed [8:0] diff;
   logic [8:0]        diff_abs;
   logic              stable;

   // Distance between the current control word and the one seen at the last edge.
   always_comb begin
      diff     = $signed({1'b0, speed_var}) - $signed({1'b0, ref_sv});
      diff_abs = diff[8] ? $unsigned(-diff) : $unsigned(diff);
      stable   = (diff_abs <= 9'(LOCK_WIN));
   end

   // Count consecutive stable edges; the first edge after reset only seeds ref_sv.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_sv     <= 8'd128;
         first_edge <= 1'b1;
         lock_cnt   <= '0;
      end else if (edge_stb) begin
         ref_sv     <= speed_var;
         first_edge <= 1'b0;
         if (!first_edge) begin
            if (!stable)
               lock_cnt <= '0;
            else if (lock_cnt != CW'(LOCK_CNT))
               lock_cnt <= lock_cnt + 1'b1;
         end
      end
   end

   assign locked = (lock_cnt == CW'(LOCK_CNT));
`else
   logic unused_lock_cfg;
   assign unused_lock_cfg = (LOCK_WIN == LOCK_CNT);
   assign locked          = 1'b0;
`endif

endmodule

// File: tb/tb_loop_nco.sv
// tb_loop_nco: scoreboard bench for loop_nco (default and GAIN_SHIFT=8 instances).
module tb_loop_nco;

`ifdef LOOP_NCO_LOCK_DET_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [7:0]  speed_var = 8'd128;
   logic        edge_stb, center_stb, locked;
   logic [15:0] phase, inc;

   logic        rst8 = 1'b0;
   logic        en8 = 1'b0;
   logic [7:0]  sv8 = 8'd128;
   logic        edge8, center8, locked8;
   logic [15:0] phase8, inc8;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   loop_nco dut (
      .clk(clk), .rst(rst), .en(en), .speed_var(speed_var),
      .edge_stb(edge_stb), .center_stb(center_stb),
      .phase(phase), .inc(inc), .locked(locked)
   );

   loop_nco #(.GAIN_SHIFT(8)) dut_g8 (
      .clk(clk), .rst(rst8), .en(en8), .speed_var(sv8),
      .edge_stb(edge8), .center_stb(center8),
      .phase(phase8), .inc(inc8), .locked(locked8)
   );

   typedef struct packed {
      logic [15:0] phase;
      logic [15:0] inc;
      logic        e_stb;
      logic        c_stb;
      logic        lock;
   } exp_t;

   exp_t sb[$];

   // reference model state
   logic [15:0] m_phase, m_inc;
   logic        m_e, m_c, m_first;
   logic [7:0]  m_ref;
   int          m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] calc_inc(input logic [7:0] sv, input int gs);
      int raw;
      raw = 4096 + ((int'(sv) - 128) * (1 << gs));
      if (raw < 1) raw = 1;
      if (raw > 32768) raw = 32768;
      return 16'(raw);
   endfunction

   task automatic model_reset();
      m_phase = 16'd0; m_inc = 16'd4096; m_e = 1'b0; m_c = 1'b0;
      m_first = 1'b1; m_ref = 8'd128; m_cnt = 0;
      sb.delete();
   endtask

   // Drive one cycle, push model expectation, then compare after the edge.
   task automatic cycle(input logic en_v, input logic [7:0] sv_v);
      exp_t        ex, got;
      logic [16:0] s;
      int          d;
      en = en_v;
      speed_var = sv_v;
      if (LOCK_ON && m_e) begin
         d = int'(sv_v) - int'(m_ref);
         if (d < 0) d = -d;
         if (!m_first) begin
            if (d > 4) m_cnt = 0;
            else if (m_cnt < 255) m_cnt++;
         end
         m_first = 1'b0;
         m_ref   = sv_v;
      end
      s = {1'b0, m_phase} + {1'b0, m_inc};
      if (en_v) begin
         m_c     = ~m_phase[15] & s[15];
         m_e     = s[16];
         m_phase = s[15:0];
      end else begin
         m_c = 1'b0;
         m_e = 1'b0;
      end
      m_inc = calc_inc(sv_v, 2);
      ex.phase = m_phase; ex.inc = m_inc; ex.e_stb = m_e; ex.c_stb = m_c;
      ex.lock = (m_cnt == 255);
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("phase",  {16'd0, phase},  {16'd0, got.phase});
      check("inc",    {16'd0, inc},    {16'd0, got.inc});
      check("edge",   {31'd0, edge_stb},   {31'd0, got.e_stb});
      check("center", {31'd0, center_stb}, {31'd0, got.c_stb});
      check("locked", {31'd0, locked},     {31'd0, got.lock});
   endtask

   // Asynchronous reset with an immediate check, released at a falling edge.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("rst_phase",  {16'd0, phase}, 32'd0);
      check("rst_inc",    {16'd0, inc},   32'd4096);
      check("rst_edge",   {31'd0, edge_stb},   32'd0);
      check("rst_center", {31'd0, center_stb}, 32'd0);
      check("rst_locked", {31'd0, locked},     32'd0);
      model_reset();
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_e, first_c, n_e, n_c, k, edges, n;
      logic [15:0] ph_at_e;
      logic        lk_exp;
      lk_exp = LOCK_ON;

      // clamping instance, GAIN_SHIFT = 8
      rst8 = 1'b1;
      #3;
      check("g8_rst_inc", {16'd0, inc8}, 32'd4096);
      @(negedge clk); rst8 = 1'b0; sv8 = 8'd255;
      @(negedge clk); @(negedge clk);
      check("g8_inc_max", {16'd0, inc8}, 32'd32768);
      en8 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check("g8_edge",   {31'd0, edge8},   (i % 2 == 0) ? 32'd1 : 32'd0);
         check("g8_center", {31'd0, center8}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk); en8 = 1'b0; sv8 = 8'd0;
      @(negedge clk); @(negedge clk);
      check("g8_inc_min", {16'd0, inc8}, 32'd1);

      // nominal rate
      do_reset();
      first_e = 0; first_c = 0; n_e = 0; n_c = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b1, 8'd128);
         if (edge_stb) begin n_e++; if (first_e == 0) first_e = i; end
         if (center_stb) begin n_c++; if (first_c == 0) first_c = i; end
      end
      check("nom_first_edge",   first_e, 16);
      check("nom_first_center", first_c, 8);
      check("nom_edges",        n_e, 2);
      check("nom_centers",      n_c, 3);

      // fast rate
      do_reset();
      cycle(1'b0, 8'd255); cycle(1'b0, 8'd255);
      check("fast_inc", {16'd0, inc}, 32'd4604);
      first_e = 0; ph_at_e = 16'd0;
      for (int i = 1; i <= 20; i++) begin
         cycle(1'b1, 8'd255);
         if (edge_stb && first_e == 0) begin first_e = i; ph_at_e = phase; end
      end
      check("fast_first_edge", first_e, 15);
      check("fast_edge_phase", {16'd0, ph_at_e}, 32'd3524);

      // slow rate
      do_reset();
      cycle(1'b0, 8'd0); cycle(1'b0, 8'd0);
      check("slow_inc", {16'd0, inc}, 32'd3584);
      first_e = 0;
      for (int i = 1; i <= 24; i++) begin
         cycle(1'b1, 8'd0);
         if (edge_stb && first_e == 0) first_e = i;
      end
      check("slow_first_edge", first_e, 19);

      // enable dropped mid-period
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'd128);
      check("en_phase_before", {16'd0, phase}, 32'd20480);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'd128);
      check("en_phase_hold", {16'd0, phase}, 32'd20480);
      k = 0;
      do begin
         cycle(1'b1, 8'd128);
         k++;
      end while (!edge_stb && k < 30);
      check("en_late_edge", 10 + k, 21);

      // reset mid-period
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'd128);
      check("rst_mid_phase", {16'd0, phase}, 32'd40960);
      #2;
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'd128);

      // lock acquire / loss (or locked stays low when compiled out)
      do_reset();
      edges = 0; n = 0;
      while (edges < 256 && n < 6000) begin
         cycle(1'b1, 8'd128);
         n++;
         if (edge_stb) edges++;
      end
      check("lock_edges",      edges, 256);
      check("lock_at_256",     {31'd0, locked}, 32'd0);
      cycle(1'b1, 8'd128);
      check("lock_after_256",  {31'd0, locked}, {31'd0, lk_exp});
      n = 0;
      while (edges < 260 && n < 200) begin
         cycle(1'b1, 8'd128);
         n++;
         if (edge_stb) edges++;
      end
      check("lock_edges_260",  edges, 260);
      n = 0;
      do begin
         cycle(1'b1, 8'd140);
         n++;
      end while (!edge_stb && n < 40);
      check("step_edge_seen",  {31'd0, edge_stb}, 32'd1);
      check("lock_hold_edge",  {31'd0, locked}, {31'd0, lk_exp});
      cycle(1'b1, 8'd140);
      check("lock_lost",       {31'd0, locked}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
